fifo_ram_ctrl: RTL and testbench
================================

# fifo_ram_ctrl

Synchronous FIFO controller that drives the team's dual-port tristate RAM as FIFO storage. RAM port 0 is the write port and RAM port 1 the read port. The controller owns the write/read pointers, occupancy count and full/empty flags. It generates registered one-cycle chip-select/write/output-enable strobes, so the RAM's level-sensitive write and address-triggered read behave deterministically. The client side is a simple enable-qualified push/pop interface.

## Interface
- DATA_WIDTH, 8, FIFO word width; must equal the RAM's DATA_WIDTH.
- ADDR_WIDTH, 8, RAM address width; must equal the RAM's ADDR_WIDTH.
- RAM_DEPTH, 1 << ADDR_WIDTH, FIFO capacity in words.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_cs  in  1  write-side select.
- wr_en  in  1  push request, qualified by wr_cs.
- data_in  in  DATA_WIDTH  push data.
- rd_cs  in  1  read-side select.
- rd_en  in  1  pop request, qualified by rd_cs.
- data_out  out  DATA_WIDTH  popped word, registered.
- rd_valid  out  1  one-cycle pulse, data_out holds a new word.
- full  out  1  count == RAM_DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_WIDTH+1  current occupancy.
- wr_err  out  1  one-cycle pulse, push attempted while full.
- rd_err  out  1  one-cycle pulse, pop attempted while empty.
- ram_address_0  out  ADDR_WIDTH  RAM port 0 address.
- ram_data_0  out  DATA_WIDTH  write data to RAM data_0.
- ram_cs_0, ram_we_0  out  1 each  port 0 write strobe.
- ram_oe_0  out  1  tied 0.
- ram_address_1  out  ADDR_WIDTH  RAM port 1 address.
- ram_data_1  in  DATA_WIDTH  read data from RAM data_1.
- ram_cs_1, ram_oe_1  out  1 each  port 1 read strobe.
- ram_we_1  out  1  tied 0.

## Operation
- **Push accept:** push_ok = wr_cs && wr_en && !full, using the pre-edge full flag.
- **Pop accept:** pop_ok = rd_cs && rd_en && !empty, using the pre-edge empty flag.
- **Push rejected while full:** no state change; wr_err pulses.
- **Pop rejected while empty:** no state change; rd_err pulses.
- **Write path:** on a push_ok edge:
  - ram_address_0 <= wr_ptr, ram_data_0 <= data_in, ram_cs_0 = ram_we_0 <= 1;
  - wr_ptr <= wr_ptr + 1, modulo RAM_DEPTH;
  - the strobe lasts exactly one cycle, then returns to 0;
  - ram_address_0 and ram_data_0 hold their values while the strobe is low.
- **Read path:** on a pop_ok edge:
  - ram_address_1 <= rd_ptr, ram_cs_1 = ram_oe_1 <= 1 for one cycle;
  - rd_ptr <= rd_ptr + 1, modulo RAM_DEPTH;
  - on the next edge (strobe high), data_out <= ram_data_1 and rd_valid <= 1 for one cycle;
  - ram_cs_1 is low between pops, so each pop re-triggers the RAM read.
- **Count:**
  - +1 on push_ok only;
  - −1 on pop_ok only;
  - unchanged when both are accepted or neither is.
- **Flags:** full and empty are registered, derived from the next count. Count never exceeds RAM_DEPTH or goes below 0.
- **Simultaneous push/pop:**
  - at full: only the pop is accepted, wr_err pulses;
  - at empty: only the push is accepted, rd_err pulses;
  - otherwise both are accepted and count is unchanged.
- **Wrap-around:** pointers are ADDR_WIDTH bits and roll from RAM_DEPTH-1 to 0 with no special handling.
- **Reset values (rst at an edge):**
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0;
  - data_out = 0, rd_valid = 0, wr_err = rd_err = 0;
  - all RAM strobes 0, ram_address_0/1 = 0, ram_data_0 = 0;
  - rst overrides push/pop on the same edge.
- **Reset mid-operation:**
  - a pending write or read strobe is cancelled;
  - no rd_valid is issued for a pop accepted on the edge before rst;
  - RAM contents are not cleared, only pointers.

## Timing
- **Push:** accepted at edge E; RAM write strobe active during cycle E..E+1; count and full update after E.
- **Pop:** accepted at edge E; read strobe during E..E+1; data_out and rd_valid valid during E+1..E+2. Pop latency is 2 edges.
- **Back-to-back pops:** one pop per cycle is sustained. The strobe may stay high across consecutive pops because the address changes every cycle.
- **Write-to-read:** a push at edge E makes empty = 0 after E. The earliest pop is accepted at E+1, and its read strobe follows the write strobe, so the read returns the written word.
- **Flag update:** full/empty/count reflect all accepted operations one cycle after the edge. There is no combinational path from wr_en/rd_en to any output.

## Test plan
- **Reset:** hold rst 2 cycles → count = 0, empty = 1, full = 0, rd_valid = 0, all ram_cs = 0; RAM strobes stay 0 with idle inputs.
- **Single word:** push 0xA5, then pop next cycle → ram_cs_0/we_0 pulse with address 0; data_out = 0xA5 with rd_valid 2 edges after the pop; empty = 1 afterwards.
- **Fill:** push 256 words 0x00..0xFF → full = 1, count = 256; a 257th push gives wr_err = 1 and count stays 256. Then 256 pops return 0x00..0xFF in order; an extra pop gives rd_err = 1.
- **Simultaneous push/pop at count 10:** count stays 10. At full: count → 255, wr_err = 1. At empty: count → 1, rd_err = 1, no rd_valid.
- **Wrap:** push/pop 300 words streaming with count 1–3 → pointers roll past 255, data order preserved, ram_address_0 goes 0xFF then 0x00.
- **Mid-op reset:** rst asserted the edge after a pop → no rd_valid, strobes 0 next cycle, count = 0, empty = 1.

Source files
------------

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller that uses an external dual-port tristate RAM as storage.
// Port 0 is the registered write port and port 1 the registered read port.
module fifo_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cs,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_cs,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wr_err,
    output logic                  rd_err,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1,
    output logic                  ram_cs_1,
    output logic                  ram_oe_1,
    output logic                  ram_we_1
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  wr_err_reg;
    logic                  rd_err_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  rd_valid_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  wstb_reg;
    logic [ADDR_WIDTH-1:0] raddr_reg;
    logic                  rstb_reg;
    logic                  push_req;
    logic                  pop_req;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance uses the registered flags, so no request input reaches an output combinationally.
    always_comb begin
        push_req   = wr_cs && wr_en;
        pop_req    = rd_cs && rd_en;
        push_ok    = push_req && !full_reg;
        pop_ok     = pop_req && !empty_reg;
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + ONE_C;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            wr_err_reg   <= 1'b0;
            rd_err_reg   <= 1'b0;
            data_out_reg <= '0;
            rd_valid_reg <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            wstb_reg     <= 1'b0;
            raddr_reg    <= '0;
            rstb_reg     <= 1'b0;
        end else begin
            count_reg  <= count_next;
            full_reg   <= (count_next == DEPTH_C);
            empty_reg  <= (count_next == '0);
            wr_err_reg <= push_req && full_reg;
            rd_err_reg <= pop_req && empty_reg;

            // Address and data hold between pushes; only the strobe drops.
            wstb_reg <= push_ok;
            if (push_ok) begin
                waddr_reg  <= wr_ptr_reg;
                wdata_reg  <= data_in;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end

            rstb_reg <= pop_ok;
            if (pop_ok) begin
                raddr_reg  <= rd_ptr_reg;
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            // RAM read data is captured one edge after the read strobe was raised.
            rd_valid_reg <= rstb_reg;
            if (rstb_reg) begin
                data_out_reg <= ram_data_1;
            end
        end
    end

    assign data_out      = data_out_reg;
    assign rd_valid      = rd_valid_reg;
    assign full          = full_reg;
    assign empty         = empty_reg;
    assign count         = count_reg;
    assign wr_err        = wr_err_reg;
    assign rd_err        = rd_err_reg;
    assign ram_address_0 = waddr_reg;
    assign ram_data_0    = wdata_reg;
    assign ram_cs_0      = wstb_reg;
    assign ram_we_0      = wstb_reg;
    assign ram_oe_0      = 1'b0;
    assign ram_address_1 = raddr_reg;
    assign ram_cs_1      = rstb_reg;
    assign ram_oe_1      = rstb_reg;
    assign ram_we_1      = 1'b0;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: behavioural RAM, queue-based reference model,
// directed plus randomized stimulus.
module tb_fifo_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_cs = 1'b0, wr_en = 1'b0, rd_cs = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid, full, empty, wr_err, rd_err;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address_0, ram_address_1;
    logic [DW-1:0] ram_data_0, ram_data_1;
    logic          ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1;

    fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
        .rd_cs(rd_cs), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid),
        .full(full), .empty(empty), .count(count),
        .wr_err(wr_err), .rd_err(rd_err),
        .ram_address_0(ram_address_0), .ram_data_0(ram_data_0),
        .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
        .ram_address_1(ram_address_1), .ram_data_1(ram_data_1),
        .ram_cs_1(ram_cs_1), .ram_oe_1(ram_oe_1), .ram_we_1(ram_we_1)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: write while port 0 strobed, read while port 1 strobed.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_data_0;
    end
    assign ram_data_1 = (ram_cs_1 && ram_oe_1) ? mem[ram_address_1] : '0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          q[$];
    int          wr_idx = 0, rd_idx = 0;
    bit          pend = 0;
    int          pend_data = 0;
    int          exp_data_out = 0, exp_addr0 = 0, exp_data0 = 0, exp_addr1 = 0;
    int          last_addr0 = -1;
    bit          seen_wrap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit push_acc, input bit pop_acc, input bit exp_valid,
                             input bit exp_werr, input bit exp_rerr);
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
        chk("data_out", 32'(data_out), 32'(exp_data_out));
        chk("wr_err", 32'(wr_err), 32'(exp_werr));
        chk("rd_err", 32'(rd_err), 32'(exp_rerr));
        chk("ram_cs_0", 32'(ram_cs_0), 32'(push_acc));
        chk("ram_we_0", 32'(ram_we_0), 32'(push_acc));
        chk("ram_address_0", 32'(ram_address_0), 32'(exp_addr0));
        chk("ram_data_0", 32'(ram_data_0), 32'(exp_data0));
        chk("ram_cs_1", 32'(ram_cs_1), 32'(pop_acc));
        chk("ram_oe_1", 32'(ram_oe_1), 32'(pop_acc));
        chk("ram_address_1", 32'(ram_address_1), 32'(exp_addr1));
        chk("ram_oe_0", 32'(ram_oe_0), 32'd0);
        chk("ram_we_1", 32'(ram_we_1), 32'd0);
    endtask

    // One clock with the given controls; model computed from pre-edge occupancy.
    task automatic step(input bit wcs, input bit wen, input logic [DW-1:0] din,
                        input bit rcs, input bit ren);
        int  sz;
        bit  push_acc, pop_acc, exp_valid, exp_werr, exp_rerr;
        wr_cs = wcs; wr_en = wen; data_in = din; rd_cs = rcs; rd_en = ren;
        @(posedge clk); #1;
        sz        = q.size();
        push_acc  = wcs && wen && (sz != DEPTH);
        pop_acc   = rcs && ren && (sz != 0);
        exp_werr  = wcs && wen && (sz == DEPTH);
        exp_rerr  = rcs && ren && (sz == 0);
        exp_valid = pend;
        if (pend) exp_data_out = pend_data;
        pend = pop_acc;
        if (pop_acc) begin
            pend_data = q.pop_front();
            exp_addr1 = rd_idx;
            rd_idx    = (rd_idx + 1) % DEPTH;
        end
        if (push_acc) begin
            q.push_back(int'(din));
            exp_addr0 = wr_idx;
            exp_data0 = int'(din);
            wr_idx    = (wr_idx + 1) % DEPTH;
            if (last_addr0 == DEPTH - 1 && exp_addr0 == 0) seen_wrap = 1;
            last_addr0 = exp_addr0;
        end
        check_all(push_acc, pop_acc, exp_valid, exp_werr, exp_rerr);
        wr_cs = 0; wr_en = 0; rd_cs = 0; rd_en = 0;
    endtask

    // Reset with push and pop requested, to show reset wins.
    task automatic do_reset(input int cycles);
        rst = 1; wr_cs = 1; wr_en = 1; rd_cs = 1; rd_en = 1; data_in = 8'h3C;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        q.delete();
        wr_idx = 0; rd_idx = 0; pend = 0; last_addr0 = -1;
        exp_data_out = 0; exp_addr0 = 0; exp_data0 = 0; exp_addr1 = 0;
        check_all(0, 0, 0, 0, 0);
        rst = 0; wr_cs = 0; wr_en = 0; rd_cs = 0; rd_en = 0;
    endtask

    initial begin
        int pushed;
        int iter;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset and idle
        do_reset(2);
        repeat (3) step(0, 0, 8'h00, 0, 0);

        // Single word
        step(1, 1, 8'hA5, 0, 0);
        chk("single_addr0", 32'(ram_address_0), 32'h0);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 0, 0);
        chk("single_data", 32'(data_out), 32'hA5);
        chk("single_valid", 32'(rd_valid), 32'd1);
        chk("single_empty", 32'(empty), 32'd1);
        step(0, 0, 8'h00, 0, 0);

        // Fill, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(i), 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd256);
        step(1, 1, 8'hEE, 0, 0);
        chk("overflow_err", 32'(wr_err), 32'd1);
        chk("overflow_count", 32'(count), 32'd256);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        chk("underflow_err", 32'(rd_err), 32'd1);
        chk("drain_last", 32'(data_out), 32'hFF);
        step(0, 0, 8'h00, 0, 0);

        // Simultaneous push/pop at count 10, at full, at empty
        for (int i = 0; i < 10; i++) step(1, 1, 8'($urandom), 0, 0);
        step(1, 1, 8'h5A, 1, 1);
        chk("simul10_count", 32'(count), 32'd10);
        for (int i = 0; i < DEPTH - 10; i++) step(1, 1, 8'($urandom), 0, 0);
        step(1, 1, 8'h77, 1, 1);
        chk("simulfull_count", 32'(count), 32'd255);
        chk("simulfull_werr", 32'(wr_err), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 0, 0);
        step(1, 1, 8'h42, 1, 1);
        chk("simulempty_count", 32'(count), 32'd1);
        chk("simulempty_rerr", 32'(rd_err), 32'd1);
        step(0, 0, 8'h00, 0, 0);
        chk("simulempty_novalid", 32'(rd_valid), 32'd0);

        // Wrap-around streaming, occupancy kept within 1..3
        do_reset(1);
        pushed = 0;
        iter = 0;
        while ((pushed < 300 || q.size() > 0) && iter < 3000) begin
            bit wen, ren;
            wen = (pushed < 300) && (q.size() < 3) && ($urandom_range(3) != 0);
            ren = ((q.size() > 1) || (pushed >= 300 && q.size() > 0)) && ($urandom_range(3) != 0);
            step(wen, wen, 8'($urandom), ren, ren);
            if (wen) pushed++;
            iter++;
        end
        chk("wrap_pushed", 32'(pushed), 32'd300);
        chk("wrap_drained", 32'(q.size()), 32'd0);
        chk("wrap_seen", 32'(seen_wrap), 32'd1);
        step(0, 0, 8'h00, 0, 0);

        // Reset the edge after a pop
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        step(0, 0, 8'h00, 1, 1);
        do_reset(1);
        chk("midrst_novalid", 32'(rd_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        step(0, 0, 8'h00, 0, 0);
        chk("midrst_novalid_late", 32'(rd_valid), 32'd0);

        // Random mixed traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), ($urandom_range(9) < 7), 8'($urandom),
                 1'($urandom), ($urandom_range(9) < 5));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), 8'($urandom), 1, ($urandom_range(9) < 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
